// File: rtl/instr_fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {FETCH, WAIT, HOLD} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port: request/grant handshake plus a separate response beat.
interface instr_fetch_if #(parameter int XLEN = 32);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/instr_fetch_skid_buf.sv
// One-entry {instruction, pc} holding register used when a response lands while EX is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [31:0]     wr_instr,
    input  logic [XLEN-1:0] wr_pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            full
);

    // Clear wins so a redirect always empties the entry, even if a load coincides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= wr_instr;
            pc    <= wr_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem read at a time and fills the IF/EX register.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_fetch_if.master   imem,
    input  logic            stall_EX,
    input  logic            redirect_EX,
    input  logic [XLEN-1:0] redirect_pc_EX,
    output logic [31:0]     instruction_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic            valid_EX
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tag_pc, tag_d;
    logic            drop, drop_d;
    logic            req_q;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_ex_d;
    logic            valid_d;
    logic            skid_load, skid_drain, skid_clear, skid_full;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            granted;
    logic [XLEN-1:0] redirect_target;

    assign granted         = req_q && imem.imem_gnt;
    assign redirect_target = redirect_pc_EX & ~XLEN'(3);
    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = pc_q;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .drain    (skid_drain),
        .clear    (skid_clear),
        .wr_instr (imem.imem_rdata),
        .wr_pc    (tag_pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    // Normal flow first; a redirect then overrides whatever the normal flow decided.
    always_comb begin
        state_d    = state;
        pc_d       = pc_q;
        tag_d      = tag_pc;
        drop_d     = drop;
        instr_d    = instruction_EX;
        pc_ex_d    = pc_EX;
        valid_d    = valid_EX;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (!stall_EX) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state)
            FETCH: begin
                if (granted) begin
                    tag_d   = pc_q;
                    pc_d    = pc_q + XLEN'(PC_STEP);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (drop) begin
                        drop_d  = 1'b0;
                        state_d = FETCH;
                    end else if (!stall_EX || !valid_EX) begin
                        instr_d = imem.imem_rdata;
                        pc_ex_d = tag_pc;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_EX && skid_full) begin
                    instr_d    = skid_instr;
                    pc_ex_d    = skid_pc;
                    valid_d    = 1'b1;
                    skid_drain = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // A grant coinciding with a redirect fetched the old path, so its response must be dropped.
        if (redirect_EX) begin
            pc_d       = redirect_target;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            skid_clear = 1'b1;
            skid_load  = 1'b0;
            skid_drain = 1'b0;
            case (state)
                FETCH: begin
                    if (granted) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_d = FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // The request is registered from next-state so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc_q           <= RESET_PC;
            tag_pc         <= RESET_PC;
            drop           <= 1'b0;
            req_q          <= 1'b0;
            instruction_EX <= NOP_INSTR;
            pc_EX          <= '0;
            valid_EX       <= 1'b0;
        end else begin
            state          <= state_d;
            pc_q           <= pc_d;
            tag_pc         <= tag_d;
            drop           <= drop_d;
            req_q          <= (state_d == FETCH);
            instruction_EX <= instr_d;
            pc_EX          <= pc_ex_d;
            valid_EX       <= valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small imem responder whose data is addr | 32'hA000_0000.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA000_0000;

    logic        clk;
    logic        rstN;
    logic        stallEx;
    logic        redirectEx;
    logic [31:0] redirectPcEx;
    logic [31:0] instructionEx;
    logic [31:0] pcEx;
    logic        validEx;

    int          checkCount;
    int          errorCount;
    logic        gntEnable;
    int          rvalidLatency;
    int          pendingCnt;
    logic [31:0] pendingAddr;

    instr_fetch_if #(.XLEN(32)) imemBus ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .imem           (imemBus),
        .stall_EX       (stallEx),
        .redirect_EX    (redirectEx),
        .redirect_pc_EX (redirectPcEx),
        .instruction_EX (instructionEx),
        .pc_EX          (pcEx),
        .valid_EX       (validEx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grants whenever enabled and idle, answers rvalidLatency cycles after the grant.
    initial begin
        imemBus.imem_gnt    = 1'b0;
        imemBus.imem_rvalid = 1'b0;
        imemBus.imem_rdata  = 32'h0;
        pendingCnt          = 0;
        pendingAddr         = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imemBus.imem_rvalid = 1'b0;
            if (pendingCnt > 0) begin
                pendingCnt = pendingCnt - 1;
                if (pendingCnt == 0) begin
                    imemBus.imem_rvalid = 1'b1;
                    imemBus.imem_rdata  = pendingAddr | TAG;
                end
            end
            imemBus.imem_gnt = imemBus.imem_req && gntEnable && (pendingCnt == 0);
            if (imemBus.imem_gnt) begin
                pendingCnt  = rvalidLatency;
                pendingAddr = imemBus.imem_addr;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkStage(input string tag, input logic expValid, input logic [31:0] expPc,
                              input logic [31:0] expInstr);
        checkOutput({tag, ".valid"}, {31'b0, validEx}, {31'b0, expValid});
        checkOutput({tag, ".pc"}, pcEx, expPc);
        checkOutput({tag, ".instr"}, instructionEx, expInstr);
    endtask

    task automatic checkReq(input string tag, input logic expReq);
        checkOutput({tag, ".req"}, {31'b0, imemBus.imem_req}, {31'b0, expReq});
    endtask

    task automatic checkAddr(input string tag, input logic [31:0] expAddr);
        checkOutput({tag, ".req"}, {31'b0, imemBus.imem_req}, 32'd1);
        checkOutput({tag, ".addr"}, imemBus.imem_addr, expAddr);
    endtask

    task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] target);
        stallEx      = stall;
        redirectEx   = redirect;
        redirectPcEx = target;
    endtask

    initial begin
        logic [31:0] expPc;
        checkCount    = 0;
        errorCount    = 0;
        gntEnable     = 1'b0;
        rvalidLatency = 1;
        rstN          = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Reset asserted mid-cycle takes effect without a clock edge.
        #2 rstN = 1'b0;
        #1;
        checkStage("reset", 1'b0, 32'h0, NOP);
        checkReq("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstN      = 1'b1;
        gntEnable = 1'b1;
        #1;
        checkReq("release_pre_edge", 1'b0);
        @(negedge clk);
        checkAddr("first_req", 32'h0);
        @(negedge clk);
        checkReq("first_wait", 1'b0);

        // Zero-wait stream: one instruction every two cycles, NOP bubble in between.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expPc = 32'(4 * i);
            checkStage("stream", 1'b1, expPc, expPc | TAG);
            @(negedge clk);
            checkStage("stream_gap", 1'b0, expPc, NOP);
        end

        // Stall while the next response lands: outputs hold, response parks in the skid buffer.
        @(negedge clk);
        checkStage("pre_stall", 1'b1, 32'h10, 32'h10 | TAG);
        applyStimulus(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkStage("stall_wait", 1'b1, 32'h10, 32'h10 | TAG);
        @(negedge clk);
        checkStage("stall_hold1", 1'b1, 32'h10, 32'h10 | TAG);
        checkReq("stall_hold1", 1'b0);
        @(negedge clk);
        checkStage("stall_hold2", 1'b1, 32'h10, 32'h10 | TAG);
        checkReq("stall_hold2", 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        rvalidLatency = 2;
        @(negedge clk);
        checkStage("skid_drain", 1'b1, 32'h14, 32'h14 | TAG);
        checkAddr("after_drain", 32'h18);

        // Redirect while waiting on 0x18; its late response must be dropped.
        @(negedge clk);
        checkStage("wait_18", 1'b0, 32'h14, NOP);
        checkReq("wait_18", 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        rvalidLatency = 1;
        checkStage("redirect_wait", 1'b0, 32'h14, NOP);
        checkReq("redirect_wait", 1'b0);
        @(negedge clk);
        checkStage("dropped_18", 1'b0, 32'h14, NOP);
        checkAddr("redirect_target", 32'h100);
        @(negedge clk);
        checkStage("fetch_100", 1'b0, 32'h14, NOP);
        @(negedge clk);
        checkStage("got_100", 1'b1, 32'h100, 32'h100 | TAG);

        // Stall and redirect together, with a grant in the same cycle that must be treated as stale.
        applyStimulus(1'b1, 1'b1, 32'h0000_0040);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkStage("stall_redirect", 1'b0, 32'h100, NOP);
        checkReq("stall_redirect", 1'b0);
        @(negedge clk);
        checkAddr("redirect_40", 32'h40);
        @(negedge clk);
        checkStage("fetch_40", 1'b0, 32'h100, NOP);
        rvalidLatency = 3;
        @(negedge clk);
        checkStage("got_40", 1'b1, 32'h40, 32'h40 | TAG);

        // Reset while waiting; the slow response then arrives as a stray beat in FETCH.
        @(negedge clk);
        checkReq("wait_44", 1'b0);
        rstN      = 1'b0;
        gntEnable = 1'b0;
        #1;
        checkStage("reset_in_wait", 1'b0, 32'h0, NOP);
        checkReq("reset_in_wait", 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkAddr("post_reset_req", 32'h0);
        @(negedge clk);
        checkStage("stray_ignored", 1'b0, 32'h0, NOP);
        checkAddr("stray_ignored", 32'h0);
        gntEnable     = 1'b1;
        rvalidLatency = 1;
        @(negedge clk);
        checkAddr("refetch_0", 32'h0);
        @(negedge clk);
        checkReq("refetch_wait", 1'b0);
        @(negedge clk);
        checkStage("first_after_reset", 1'b1, 32'h0, 32'h0 | TAG);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
